// File: rtl/stream_demux_pkg.sv
// Shared defaults and constants for the stream demultiplexer.
package stream_demux_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_NCH   = 4;
    localparam int DROP_CNT_W    = 8;

endpackage : stream_demux_pkg

// File: rtl/demux_sel_dec.sv
// Combinational select decoder: turns (in_sel, in_bcast) into a channel mask
// and flags selects that address no existing channel.
module demux_sel_dec #(
    parameter int NCH  = 4,
    parameter int SELW = $clog2(NCH)
) (
    input  logic [SELW-1:0] in_sel,
    input  logic            in_bcast,
    output logic [NCH-1:0]  mask,
    output logic            bad
);

    logic [NCH-1:0] onehot;

    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NCH; i++) begin
            if (in_sel == SELW'(i)) begin
                onehot[i] = 1'b1;
            end
        end
    end

    // A select that matches no channel decodes to an empty one-hot mask.
    always_comb begin
        mask = '0;
        bad  = 1'b0;
        if (in_bcast) begin
            mask = '1;
        end else if (onehot == '0) begin
            bad  = 1'b1;
        end else begin
            mask = onehot;
        end
    end

endmodule : demux_sel_dec

// File: rtl/stream_demux.sv
// One-deep stream demultiplexer: a single data register feeds NCH channels
// through a pending mask; broadcast holds the word until every channel drains.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NCH   = DEFAULT_NCH,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [SELW-1:0]       in_sel,
    input  logic                  in_bcast,
    output logic [NCH-1:0]        out_valid,
    input  logic [NCH-1:0]        out_ready,
    output logic [NCH*WIDTH-1:0]  out_data,
    output logic                  err_sel,
    input  logic                  err_clr,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    logic [WIDTH-1:0]      data_q;
    logic [NCH-1:0]        pend_q;
    logic                  err_q;
    logic [DROP_CNT_W-1:0] drop_q;

    logic [NCH-1:0]        dec_mask;
    logic                  dec_bad;
    logic                  accept;
    logic                  bad_accept;

    demux_sel_dec #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_sel_dec (
        .in_sel   (in_sel),
        .in_bcast (in_bcast),
        .mask     (dec_mask),
        .bad      (dec_bad)
    );

    // Ready as soon as every still-pending channel completes this cycle.
    assign in_ready   = ~|(pend_q & ~out_ready);
    assign accept     = in_valid & in_ready;
    assign bad_accept = accept & dec_bad;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            data_q <= '0;
        end else if (accept) begin
            pend_q <= dec_mask;
            data_q <= in_data;
        end else begin
            pend_q <= pend_q & ~out_ready;
        end
    end

    // A bad select in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            if (bad_accept) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
            if (bad_accept && (drop_q != '1)) begin
                drop_q <= drop_q + DROP_CNT_W'(1);
            end
        end
    end

    assign out_valid = pend_q;
    assign err_sel   = err_q;
    assign drop_cnt  = drop_q;

    for (genvar i = 0; i < NCH; i++) begin : g_out
        assign out_data[i*WIDTH +: WIDTH] = pend_q[i] ? data_q : '0;
    end

endmodule : stream_demux

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux: a 4-channel and a 3-channel instance
// driven by directed vectors; monitors pop expected words on each transfer.
module tb_stream_demux;

    typedef struct {
        int         ch;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    logic        iv4, ir4, ib4, es4, ec4;
    logic [1:0]  is4;
    logic [7:0]  id4, dc4;
    logic [3:0]  ov4, or4;
    logic [31:0] od4;

    logic        iv3, ir3, ib3, es3, ec3;
    logic [1:0]  is3;
    logic [7:0]  id3, dc3;
    logic [2:0]  ov3, or3;
    logic [23:0] od3;

    exp_t sb4[$];
    exp_t sb3[$];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stream_demux #(.WIDTH(8), .NCH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
        .in_sel(is4), .in_bcast(ib4), .out_valid(ov4), .out_ready(or4),
        .out_data(od4), .err_sel(es4), .err_clr(ec4), .drop_cnt(dc4)
    );

    stream_demux #(.WIDTH(8), .NCH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .in_data(id3),
        .in_sel(is3), .in_bcast(ib3), .out_valid(ov3), .out_ready(or3),
        .out_data(od3), .err_sel(es3), .err_clr(ec3), .drop_cnt(dc3)
    );

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect4(input string name, input logic [3:0] valid, input logic ready);
        @(negedge clk);
        check({name, "_valid"}, ov4, valid);
        check({name, "_ready"}, ir4, ready);
    endtask

    task automatic expect3(input string name, input logic [2:0] valid, input logic ready);
        @(negedge clk);
        check({name, "_valid"}, ov3, valid);
        check({name, "_ready"}, ir3, ready);
    endtask

    // Monitors: every channel transfer must match the oldest word queued for it.
    always @(negedge clk) begin
        int idx;
        for (int i = 0; i < 4; i++) begin
            if (rst_n && ov4[i] && or4[i]) begin
                idx = -1;
                for (int k = 0; k < sb4.size(); k++)
                    if (idx < 0 && sb4[k].ch == i) idx = k;
                if (idx < 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb4_unexpected ch%0d: got %0h, expected no transfer", i, od4[i*8 +: 8]);
                end else begin
                    check($sformatf("sb4_ch%0d", i), od4[i*8 +: 8], sb4[idx].data);
                    sb4.delete(idx);
                end
            end
        end
    end

    always @(negedge clk) begin
        int idx;
        for (int i = 0; i < 3; i++) begin
            if (rst_n && ov3[i] && or3[i]) begin
                idx = -1;
                for (int k = 0; k < sb3.size(); k++)
                    if (idx < 0 && sb3[k].ch == i) idx = k;
                if (idx < 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb3_unexpected ch%0d: got %0h, expected no transfer", i, od3[i*8 +: 8]);
                end else begin
                    check($sformatf("sb3_ch%0d", i), od3[i*8 +: 8], sb3[idx].data);
                    sb3.delete(idx);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        iv4 = 0; ib4 = 0; is4 = 0; id4 = 0; ec4 = 0; or4 = 4'b1111;
        iv3 = 0; ib3 = 0; is3 = 0; id3 = 0; ec3 = 0; or3 = 3'b111;
        #2;
        check("rst_valid", ov4, 4'b0000);
        check("rst_ready", ir4, 1'b1);
        check("rst_err", es4, 1'b0);
        check("rst_drop", dc4, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Streaming to each channel in turn with all sinks ready.
        step(); iv4 = 1; is4 = 0; id4 = 8'h11; sb4.push_back('{ch: 0, data: 8'h11});
        expect4("seq0", 4'b0000, 1'b1);
        step(); is4 = 1; id4 = 8'h22; sb4.push_back('{ch: 1, data: 8'h22});
        expect4("seq1", 4'b0001, 1'b1);
        step(); is4 = 2; id4 = 8'h33; sb4.push_back('{ch: 2, data: 8'h33});
        expect4("seq2", 4'b0010, 1'b1);
        step(); is4 = 3; id4 = 8'h44; sb4.push_back('{ch: 3, data: 8'h44});
        expect4("seq3", 4'b0100, 1'b1);
        step(); iv4 = 0;
        expect4("seq4", 4'b1000, 1'b1);
        step();
        expect4("seq5", 4'b0000, 1'b1);

        // Backpressure on channel 2 for three cycles.
        step(); iv4 = 1; is4 = 2; id4 = 8'hA5; or4 = 4'b1011; sb4.push_back('{ch: 2, data: 8'hA5});
        expect4("bp_acc", 4'b0000, 1'b1);
        for (int n = 0; n < 3; n++) begin
            step(); iv4 = 0;
            expect4($sformatf("bp_hold%0d", n), 4'b0100, 1'b0);
            check($sformatf("bp_data%0d", n), od4, 32'h00A5_0000);
        end
        step(); or4 = 4'b1111;
        expect4("bp_xfer", 4'b0100, 1'b1);
        step();
        expect4("bp_done", 4'b0000, 1'b1);

        // Broadcast drained in two halves, next word accepted on the last one.
        step(); iv4 = 1; ib4 = 1; id4 = 8'h5A; or4 = 4'b0101;
        for (int c = 0; c < 4; c++) sb4.push_back('{ch: c, data: 8'h5A});
        expect4("bc_acc", 4'b0000, 1'b1);
        step(); iv4 = 0; ib4 = 0;
        expect4("bc_half1", 4'b1111, 1'b0);
        check("bc_data", od4, 32'h5A5A_5A5A);
        step(); or4 = 4'b1010; iv4 = 1; is4 = 0; id4 = 8'h77; sb4.push_back('{ch: 0, data: 8'h77});
        expect4("bc_half2", 4'b1010, 1'b1);
        check("bc_data2", od4, 32'h5A00_5A00);
        step(); iv4 = 0; or4 = 4'b1111;
        expect4("bc_next", 4'b0001, 1'b1);
        step();
        expect4("bc_done", 4'b0000, 1'b1);

        // Bad selects on the 3-channel instance.
        step(); iv3 = 1; is3 = 3; id3 = 8'hEE;
        expect3("bad_acc", 3'b000, 1'b1);
        step(); is3 = 1; id3 = 8'h3C; sb3.push_back('{ch: 1, data: 8'h3C});
        expect3("bad_drop", 3'b000, 1'b1);
        check("bad_err", es3, 1'b1);
        check("bad_cnt1", dc3, 8'd1);
        for (int n = 0; n < 300; n++) begin
            step(); iv3 = 1; is3 = 3; id3 = n[7:0];
        end
        step(); iv3 = 0; ec3 = 1;
        @(negedge clk);
        check("sat_cnt", dc3, 8'd255);
        check("sat_err", es3, 1'b1);
        check("sat_valid", ov3, 3'b000);
        step(); ec3 = 0;
        @(negedge clk);
        check("clr_err", es3, 1'b0);
        step(); iv3 = 1; is3 = 3; ec3 = 1;
        step(); iv3 = 0; ec3 = 0;
        @(negedge clk);
        check("setwins_err", es3, 1'b1);
        check("setwins_cnt", dc3, 8'd255);

        // Reset in the middle of a stalled word.
        step(); iv4 = 1; is4 = 2; id4 = 8'h99; or4 = 4'b0000;
        step(); iv4 = 0;
        expect4("pre_rst", 4'b0100, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", ov4, 4'b0000);
        check("arst_ready", ir4, 1'b1);
        check("arst_data", od4, 32'h0);
        check("arst_err3", es3, 1'b0);
        check("arst_drop3", dc3, 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; or4 = 4'b1111;
        iv4 = 1; is4 = 1; id4 = 8'h42; sb4.push_back('{ch: 1, data: 8'h42});
        expect4("post_rst", 4'b0000, 1'b1);
        step(); iv4 = 0;
        expect4("first_acc", 4'b0010, 1'b1);
        step();
        expect4("post_done", 4'b0000, 1'b1);

        check("sb4_empty", sb4.size(), 0);
        check("sb3_empty", sb3.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_stream_demux

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter WIDTH, default 8: payload width in bits, legal range 1..64.
REQ-002 Parameter NCH, default 4: number of output channels, legal range 2..16.
REQ-003 Parameter SELW, default $clog2(NCH): width of the channel-select field.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 in_valid  input  1  source holds a word.
REQ-007 in_ready  output  1  block accepts the word this cycle.
REQ-008 in_data  input  WIDTH  payload.
REQ-009 in_sel  input  SELW  destination channel index.
REQ-010 in_bcast  input  1  when 1, send the word to all NCH channels and ignore in_sel.
REQ-011 out_valid  output  NCH  per-channel valid.
REQ-012 out_ready  input  NCH  per-channel sink ready.
REQ-013 out_data  output  NCH*WIDTH  per-channel payload; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-014 err_sel  output  1  sticky flag for a bad select.
REQ-015 err_clr  input  1  synchronous clear for err_sel.
REQ-016 drop_cnt  output  8  count of dropped words, saturating.

Function
REQ-017 State SHALL be one data register data_q[WIDTH] and one pending mask pend[NCH]; the block is empty when pend==0.
REQ-018 out_valid SHALL equal pend, and out_data channel i SHALL equal data_q when pend[i]=1, otherwise 0.
REQ-019 A channel transfer SHALL occur on channel i when out_valid[i] && out_ready[i]; that transfer clears pend[i] at the next edge.
REQ-020 in_ready SHALL be 1 when (pend & ~out_ready)==0, i.e. when every pending channel completes this cycle. This is combinational from out_ready, with no dependence on in_valid.
REQ-021 On in_valid && in_ready, data_q SHALL load in_data and pend SHALL load the decoded mask, replacing the drained mask in the same cycle. This gives full throughput of 1 word/cycle.
REQ-022 Decoded mask: all ones when in_bcast=1; one-hot bit in_sel when in_sel<NCH; zero otherwise.
REQ-023 Latency: a word accepted at edge k SHALL present out_valid from cycle k+1.
REQ-024 Broadcast: the word SHALL remain on each channel until that channel transfers. Channels may complete in different cycles, and the next word is not accepted until all of them have completed.
REQ-025 Bad select (in_bcast=0, in_sel>=NCH, accepted): the word SHALL be dropped (pend loads 0), err_sel SHALL set, and drop_cnt SHALL increment, holding at 255.
REQ-026 When a bad-select accept and err_clr occur in the same cycle, err_sel SHALL end at 1 (set wins).
REQ-027 out_valid[i] SHALL NOT drop and data_q SHALL NOT change while pend[i]=1 and out_ready[i]=0.
REQ-028 When in_valid=0, pend SHALL update as pend & ~out_ready.

Reset
REQ-029 While rst_n=0: pend=0, data_q=0, err_sel=0, drop_cnt=0.
REQ-030 While rst_n=0, all out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-031 Reset asserted mid-transfer SHALL discard pending words with no partial delivery after release.
REQ-032 The first accept SHALL be possible at the first rising edge after rst_n deasserts.

Structure
REQ-033 Package stream_demux_pkg SHALL hold the default WIDTH and NCH values and the DROP_CNT_W=8 constant.
REQ-034 Select decoding (in_sel, in_bcast -> mask, bad flag) SHALL live in the combinational sub-module demux_sel_dec.
REQ-035 The top level holds only registers and handshake logic, with no latches, and SHALL be synthesizable for all legal parameter values.

Verification
REQ-036 WIDTH=8, NCH=4, all out_ready=1; send sel=0,1,2,3 with data 0x11,0x22,0x33,0x44 on 4 consecutive cycles -> out_valid=0001,0010,0100,1000 with matching data on cycles 1-4, in_ready stays 1.
REQ-037 Backpressure: sel=2, data 0xA5, out_ready[2]=0 for 3 cycles -> out_valid[2] and 0xA5 held for 3 cycles with in_ready=0, then transfer and in_ready=1.
REQ-038 Broadcast: in_bcast=1, data 0x5A, out_ready=0101 then 1010 -> channels 0,2 transfer first, then 1,3; in_ready=1 only in the second cycle.
REQ-039 NCH=3, sel=3 -> word dropped, out_valid=000, err_sel=1, drop_cnt=1; 300 bad words -> drop_cnt=255; err_clr with a simultaneous bad word -> err_sel remains 1.
REQ-040 rst_n pulsed low while pend=0100 -> out_valid=0 immediately (asynchronously), err_sel=0, drop_cnt=0, in_ready=1.
